dca_matrix_lsu_store_packer: RTL and testbench
==============================================

// Module: dca_matrix_lsu_store_packer
// PURPOSE
// - Store-side counterpart of the matrix LSU load unpacker.
// - Takes one row of MATRIX_NUM_COL LSU elements, optionally saturates each element, and truncates it to the memory element width (2^lsa_p3 bits).
// - Packs the row densely into the memory row buffer and generates byte strobes.
// - Hands the packed row to the AXI write datapath through a 2-entry skid buffer, with a registered output and full throughput.
// PARAMETERS
// - MATRIX_NUM_COL   4   elements per row
// - BW_LSU_ELEMENT   32  LSU element width; must be >= 32
// - BW_TXN_INFO      8   transaction tag width; passed through untouched
// - BW_ROW_BUF       32*MATRIX_NUM_COL (derived)  memory row buffer width
// PORTS
// - clk             in   1                         clock
// - rstnn           in   1                         asynchronous reset, active low
// - clear           in   1                         synchronous flush
// - enable          in   1                         accept enable
// - sinfo_lsa_p3    in   3                         log2 of element bit width; 0..5 valid, >5 treated as 5
// - sinfo_is_signed in   1                         input elements are two's complement
// - sinfo_saturate  in   1                         clamp instead of wrap on truncation
// - sreq_valid      in   1                         input row valid
// - sreq_ready      out  1                         input row accepted when valid&ready
// - sreq_row        in   BW_LSU_ELEMENT*MATRIX_NUM_COL  element i at [BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT]
// - sreq_txn_info   in   BW_TXN_INFO               tag travelling with the row
// - wbuf_valid      out  1                         packed row valid
// - wbuf_ready      in   1                         downstream accepts
// - wbuf_data       out  BW_ROW_BUF                packed row
// - wbuf_strb       out  BW_ROW_BUF/8              byte strobes
// - wbuf_txn_info   out  BW_TXN_INFO               tag of the packed row
// - ovf_sticky      out  1                         set when any element was clamped or wrapped out of range
// BEHAVIOUR
// - Reset values: wbuf_valid=0, ovf_sticky=0, both buffer entries empty. wbuf_data, wbuf_strb and wbuf_txn_info reset to 0.
// - Sampling: the sinfo_* inputs are captured on each accepted beat together with the row. A change of sinfo_* never alters rows already accepted.
// - Width: W = 1<<min(sinfo_lsa_p3,5).
// - Saturation, signed mode, saturate=1: clamp element to [-2^(W-1), 2^(W-1)-1].
// - Saturation, unsigned mode, saturate=1: clamp element to [0, 2^W-1]. For W=32 this is a plain truncation of the low 32 bits.
// - saturate=0: keep the low W bits (wrap).
// - Overflow: an element is out of range when it lies outside the clamp range above, in either saturate mode. Any out-of-range element sets ovf_sticky on acceptance. ovf_sticky clears only on clear or reset.
// - Packing: element i, low W bits, goes to wbuf_data[W*i +: W]. All bits >= W*MATRIX_NUM_COL are 0.
// - Strobes: strb[b]=1 iff byte b holds any bit < W*MATRIX_NUM_COL. A sub-byte total still sets strb[0].
// - Pipeline: pack/saturate logic is combinational on the input; the result is registered into the main output register.
//   - Latency is 1 cycle from acceptance to wbuf_valid.
//   - Main register full and wbuf_ready=0 at acceptance: the beat goes to the skid register.
//   - sreq_ready = enable & ~skid_full. Registered, no combinational path from wbuf_ready.
//   - Transfer at wbuf_valid&wbuf_ready. The skid entry moves to the main register in the same cycle, and a simultaneous new beat refills behind it. Order is strictly preserved.
//   - Throughput is 1 row per cycle while wbuf_ready=1.
// - Output hold: while wbuf_valid=1 and wbuf_ready=0, wbuf_* are held stable.
// - enable=0: stalls input only. Buffered rows still drain and valid is never dropped.
// - clear=1: empties both entries and drops wbuf_valid the next cycle, even mid-handshake. No beat is accepted in that cycle; clear overrides any sreq or wbuf handshake in the same cycle. ovf_sticky is cleared.
// - Reset asserted mid-operation: all pending rows are discarded immediately (asynchronous).
// TESTING
// 1. lsa_p3=3, signed, sat=0, row {0x1FF,-1,0x80,5}, 4 cols
//    -> data[31:0]=0x0580FFFF, strb=0x000F, ovf_sticky=1 (0x1FF and 0x80 out of range).
// 2. Same row, sat=1
//    -> data[31:0]=0x057FFF7F, ovf_sticky=1.
// 3. lsa_p3=0, unsigned, row {1,0,1,1}
//    -> data[3:0]=4'b1101, strb=0x0001.
// 4. lsa_p3=5, back-to-back 4 rows, wbuf_ready held 0 for 3 cycles
//    -> only 2 rows accepted, sreq_ready drops.
//    -> After wbuf_ready rises, the rows emerge in order with no loss or duplication, and wbuf_data is stable while stalled.
// 5. clear asserted while wbuf_valid=1, skid full and sreq_valid=1
//    -> next cycle wbuf_valid=0, sreq_ready=enable, ovf_sticky=0, and no row is accepted in the clear cycle.
// 6. lsa_p3=7
//    -> identical to lsa_p3=5.
//    Change sinfo_lsa_p3 while a row is stalled in the buffer -> the buffered output is unchanged.

Source files
------------

// File: rtl/dca_matrix_lsu_store_packer.sv
// Store-side row packer for the matrix LSU.
// Saturates or wraps each LSU element to the memory element width (2^lsa_p3 bits),
// packs the row densely with byte strobes, and presents it through a
// 2-entry skid buffer (main output register + skid register).
module dca_matrix_lsu_store_packer #(
  parameter int MATRIX_NUM_COL = 4,
  parameter int BW_LSU_ELEMENT = 32,
  parameter int BW_TXN_INFO    = 8,
  parameter int BW_ROW_BUF     = 32 * MATRIX_NUM_COL
) (
  input  logic                                     clk,
  input  logic                                     rstnn,
  input  logic                                     clear,
  input  logic                                     enable,
  input  logic [2:0]                               sinfo_lsa_p3,
  input  logic                                     sinfo_is_signed,
  input  logic                                     sinfo_saturate,
  input  logic                                     sreq_valid,
  output logic                                     sreq_ready,
  input  logic [BW_LSU_ELEMENT*MATRIX_NUM_COL-1:0] sreq_row,
  input  logic [BW_TXN_INFO-1:0]                   sreq_txn_info,
  output logic                                     wbuf_valid,
  input  logic                                     wbuf_ready,
  output logic [BW_ROW_BUF-1:0]                    wbuf_data,
  output logic [BW_ROW_BUF/8-1:0]                  wbuf_strb,
  output logic [BW_TXN_INFO-1:0]                   wbuf_txn_info,
  output logic                                     ovf_sticky
);

  localparam int NUM_BYTES = BW_ROW_BUF / 8;

  logic [2:0]                lsa_eff;
  int                        w_bits;
  logic [31:0]               w_mask;
  logic [BW_LSU_ELEMENT-1:0] lo_ext;
  logic [BW_LSU_ELEMENT-1:0] sg_ext;
  logic [BW_LSU_ELEMENT-1:0] elem;
  logic [BW_LSU_ELEMENT-1:0] elem_hi;
  logic                      elem_ovf;
  logic [31:0]               elem_val;
  logic [BW_ROW_BUF-1:0]     pack_data;
  logic [NUM_BYTES-1:0]      pack_strb;
  logic                      pack_ovf;

  logic                      m_valid;
  logic [BW_ROW_BUF-1:0]     m_data;
  logic [NUM_BYTES-1:0]      m_strb;
  logic [BW_TXN_INFO-1:0]    m_txn;
  logic                      s_valid;
  logic [BW_ROW_BUF-1:0]     s_data;
  logic [NUM_BYTES-1:0]      s_strb;
  logic [BW_TXN_INFO-1:0]    s_txn;
  logic                      ovf_q;
  logic                      accept;

  // Ready depends only on the skid flop, never on wbuf_ready.
  assign sreq_ready    = enable & ~s_valid;
  assign accept        = sreq_valid & sreq_ready & ~clear;
  assign wbuf_valid    = m_valid;
  assign wbuf_data     = m_data;
  assign wbuf_strb     = m_strb;
  assign wbuf_txn_info = m_txn;
  assign ovf_sticky    = ovf_q;

  // Combinational saturate/truncate/pack of the incoming row with its own sinfo.
  always_comb begin
    lsa_eff   = (sinfo_lsa_p3 > 3'd5) ? 3'd5 : sinfo_lsa_p3;
    w_bits    = 1 << lsa_eff;
    case (lsa_eff)
      3'd0:    w_mask = 32'h0000_0001;
      3'd1:    w_mask = 32'h0000_0003;
      3'd2:    w_mask = 32'h0000_000F;
      3'd3:    w_mask = 32'h0000_00FF;
      3'd4:    w_mask = 32'h0000_FFFF;
      default: w_mask = 32'hFFFF_FFFF;
    endcase
    lo_ext    = BW_LSU_ELEMENT'(w_mask);
    sg_ext    = BW_LSU_ELEMENT'(w_mask >> 1);
    pack_data = '0;
    pack_strb = '0;
    pack_ovf  = 1'b0;
    elem      = '0;
    elem_hi   = '0;
    elem_ovf  = 1'b0;
    elem_val  = '0;
    for (int i = 0; i < MATRIX_NUM_COL; i++) begin
      elem = sreq_row[BW_LSU_ELEMENT*i +: BW_LSU_ELEMENT];
      if (sinfo_is_signed) begin
        // In range iff everything from bit W-1 upward is a pure sign extension.
        elem_hi  = elem & ~sg_ext;
        elem_ovf = (elem_hi != '0) && (elem_hi != ~sg_ext);
        if (sinfo_saturate && elem_ovf)
          elem_val = elem[BW_LSU_ELEMENT-1] ? ((w_mask >> 1) + 32'd1) : (w_mask >> 1);
        else
          elem_val = elem[31:0] & w_mask;
      end else begin
        elem_hi  = elem & ~lo_ext;
        elem_ovf = (elem_hi != '0);
        elem_val = (sinfo_saturate && elem_ovf) ? w_mask : (elem[31:0] & w_mask);
      end
      pack_data = pack_data | (BW_ROW_BUF'(elem_val) << (w_bits * i));
      pack_ovf  = pack_ovf | elem_ovf;
    end
    for (int b = 0; b < NUM_BYTES; b++)
      pack_strb[b] = ((8 * b) < (w_bits * MATRIX_NUM_COL));
  end

  // Main/skid registers and sticky overflow; clear wins over every handshake.
  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_strb  <= '0;
      m_txn   <= '0;
      s_valid <= 1'b0;
      s_data  <= '0;
      s_strb  <= '0;
      s_txn   <= '0;
      ovf_q   <= 1'b0;
    end else if (clear) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (accept && pack_ovf)
        ovf_q <= 1'b1;
      if (!m_valid || wbuf_ready) begin
        if (s_valid) begin
          m_valid <= 1'b1;
          m_data  <= s_data;
          m_strb  <= s_strb;
          m_txn   <= s_txn;
          s_valid <= 1'b0;
        end else begin
          m_valid <= accept;
          if (accept) begin
            m_data <= pack_data;
            m_strb <= pack_strb;
            m_txn  <= sreq_txn_info;
          end
        end
      end else if (accept) begin
        s_valid <= 1'b1;
        s_data  <= pack_data;
        s_strb  <= pack_strb;
        s_txn   <= sreq_txn_info;
      end
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_store_packer.sv
// Bench for dca_matrix_lsu_store_packer: fixed vectors, scripted buffer corner cases,
// and random traffic against an arithmetic reference model with an in-order queue.
module tb_dca_matrix_lsu_store_packer;

  localparam int N   = 4;
  localparam int BWE = 32;
  localparam int BWT = 8;
  localparam int BWR = 32 * N;
  localparam int NB  = BWR / 8;

  logic           clk = 1'b0;
  logic           rstnn, clear, enable;
  logic [2:0]     lsa;
  logic           sgn, sat, sreq_valid, wbuf_ready;
  logic           sreq_ready, wbuf_valid, ovf_sticky;
  logic [BWE*N-1:0] sreq_row;
  logic [BWT-1:0] sreq_txn_info, wbuf_txn_info;
  logic [BWR-1:0] wbuf_data;
  logic [NB-1:0]  wbuf_strb;

  dca_matrix_lsu_store_packer #(
    .MATRIX_NUM_COL(N), .BW_LSU_ELEMENT(BWE), .BW_TXN_INFO(BWT), .BW_ROW_BUF(BWR)
  ) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .enable(enable),
    .sinfo_lsa_p3(lsa), .sinfo_is_signed(sgn), .sinfo_saturate(sat),
    .sreq_valid(sreq_valid), .sreq_ready(sreq_ready), .sreq_row(sreq_row),
    .sreq_txn_info(sreq_txn_info), .wbuf_valid(wbuf_valid), .wbuf_ready(wbuf_ready),
    .wbuf_data(wbuf_data), .wbuf_strb(wbuf_strb), .wbuf_txn_info(wbuf_txn_info),
    .ovf_sticky(ovf_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BWR-1:0] data;
    logic [NB-1:0]  strb;
    logic [BWT-1:0] txn;
  } beat_t;

  typedef struct {
    logic [2:0]     l;
    bit             s;
    bit             st;
    logic [127:0]   row;
    logic [127:0]   d;
    logic [15:0]    sb;
    bit             ov;
  } vec_t;

  beat_t q[$];
  bit    m_ovf;
  int    n_chk = 0;
  int    n_fail = 0;
  bit    last_acc;
  int    n_acc = 0;
  int    n_out = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer range check, clamp, then modulo-2^W placement.
  function automatic void model(input logic [127:0] row, input logic [2:0] l, input bit s,
                                input bit st, output logic [BWR-1:0] d,
                                output logic [NB-1:0] sb, output bit ov);
    int          w;
    longint      v, lo, hi, mask;
    logic [31:0] e;
    w    = (l > 3'd5) ? 32 : (1 << l);
    mask = (longint'(1) << w) - 1;
    d    = '0;
    ov   = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = row[32*i +: 32];
      if (s) begin
        v  = longint'($signed(e));
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
      end else begin
        v  = longint'({32'b0, e});
        lo = 0;
        hi = mask;
      end
      if (v < lo || v > hi) begin
        ov = 1'b1;
        if (st) v = (v < lo) ? lo : hi;
      end
      d = d | (BWR'(v & mask) << (w * i));
    end
    for (int b = 0; b < NB; b++) sb[b] = ((8 * b) < (w * N));
  endfunction

  task automatic drive(input bit v, input logic [127:0] row, input logic [2:0] l, input bit s,
                       input bit st, input logic [7:0] t, input bit rdy, input bit en,
                       input bit clr);
    sreq_valid = v; sreq_row = row; lsa = l; sgn = s; sat = st;
    sreq_txn_info = t; wbuf_ready = rdy; enable = en; clear = clr;
  endtask

  // One cycle: check outputs against the model state, then advance the model across the edge.
  task automatic step();
    bit    acc, fire, ov;
    beat_t b;
    #1;
    chk("wbuf_valid", 128'(wbuf_valid), 128'(q.size() != 0));
    if (q.size() != 0) begin
      chk("wbuf_data", 128'(wbuf_data), 128'(q[0].data));
      chk("wbuf_strb", 128'(wbuf_strb), 128'(q[0].strb));
      chk("wbuf_txn_info", 128'(wbuf_txn_info), 128'(q[0].txn));
    end
    chk("sreq_ready", 128'(sreq_ready), 128'(enable && q.size() < 2));
    chk("ovf_sticky", 128'(ovf_sticky), 128'(m_ovf));
    acc  = sreq_valid && enable && (q.size() < 2) && !clear;
    fire = (q.size() != 0) && wbuf_ready;
    if (clear) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      if (fire) begin
        void'(q.pop_front());
        n_out++;
      end
      if (acc) begin
        model(sreq_row, lsa, sgn, sat, b.data, b.strb, ov);
        b.txn = sreq_txn_info;
        q.push_back(b);
        if (ov) m_ovf = 1'b1;
        n_acc++;
      end
    end
    last_acc = acc;
    @(negedge clk);
  endtask

  function automatic logic [127:0] rnd_row();
    logic [127:0] r;
    logic [31:0]  e;
    for (int i = 0; i < N; i++) begin
      e = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0) e = -e;
      r[32*i +: 32] = e;
    end
    return r;
  endfunction

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] rows[4];
    int           cnt, a0, o0, idx;

    vecs[0] = '{3'd3, 1, 0, {32'd5, 32'h80, 32'hFFFF_FFFF, 32'h1FF}, 128'h0580FFFF, 16'h000F, 1};
    vecs[1] = '{3'd3, 1, 1, {32'd5, 32'h80, 32'hFFFF_FFFF, 32'h1FF}, 128'h057FFF7F, 16'h000F, 1};
    vecs[2] = '{3'd0, 0, 0, {32'd1, 32'd1, 32'd0, 32'd1}, 128'hD, 16'h0001, 0};
    vecs[3] = '{3'd7, 1, 1, {32'hDEADBEEF, 32'h12345678, 32'h80000000, 32'h7FFFFFFF},
                128'hDEADBEEF_12345678_80000000_7FFFFFFF, 16'hFFFF, 0};
    vecs[4] = '{3'd5, 1, 1, {32'hDEADBEEF, 32'h12345678, 32'h80000000, 32'h7FFFFFFF},
                128'hDEADBEEF_12345678_80000000_7FFFFFFF, 16'hFFFF, 0};
    vecs[5] = '{3'd4, 0, 1, {32'hFFFF_FFFF, 32'h1, 32'hFFFF, 32'h10000},
                128'hFFFF_0001_FFFF_FFFF, 16'h00FF, 1};
    vecs[6] = '{3'd1, 1, 1, {32'hFFFF_FFFD, 32'd2, 32'hFFFF_FFFE, 32'd1}, 128'h99, 16'h0001, 1};
    vecs[7] = '{3'd2, 0, 0, {32'hA, 32'h10, 32'h3, 32'hF}, 128'hA03F, 16'h0003, 1};

    rstnn = 1'b0;
    drive(0, '0, 3'd0, 0, 0, 8'h0, 0, 1, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset wbuf_valid", 128'(wbuf_valid), 128'(0));
    chk("reset wbuf_data", 128'(wbuf_data), 128'(0));
    chk("reset wbuf_strb", 128'(wbuf_strb), 128'(0));
    chk("reset wbuf_txn_info", 128'(wbuf_txn_info), 128'(0));
    chk("reset ovf_sticky", 128'(ovf_sticky), 128'(0));
    chk("reset sreq_ready", 128'(sreq_ready), 128'(1));
    @(negedge clk);
    rstnn = 1'b1;

    // Fixed vectors: clear, one beat, compare the emerging row to the table.
    for (int k = 0; k < 8; k++) begin
      drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 1);
      step();
      drive(1, vecs[k].row, vecs[k].l, vecs[k].s, vecs[k].st, 8'(k + 8'h40), 1, 1, 0);
      step();
      #1;
      chk($sformatf("vec%0d data", k), 128'(wbuf_data), vecs[k].d);
      chk($sformatf("vec%0d strb", k), 128'(wbuf_strb), 128'(vecs[k].sb));
      chk($sformatf("vec%0d ovf", k), 128'(ovf_sticky), 128'(vecs[k].ov));
      chk($sformatf("vec%0d txn", k), 128'(wbuf_txn_info), 128'(k + 8'h40));
      drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 0);
      step();
    end

    // Four back-to-back rows with the output stalled for three cycles.
    drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 1);
    step();
    for (int i = 0; i < 4; i++) rows[i] = rnd_row();
    a0 = n_acc; o0 = n_out; idx = 0; cnt = 0;
    for (int c = 0; c < 20; c++) begin
      drive(idx < 4, (idx < 4) ? rows[idx] : '0, 3'd5, 1, 0, 8'(8'h80 + idx), c >= 3, 1, 0);
      step();
      if (last_acc) idx++;
      if (c == 2) cnt = n_acc - a0;
    end
    chk("stall accepts", 128'(cnt), 128'(2));
    chk("stall total accepts", 128'(n_acc - a0), 128'(4));
    chk("stall total outputs", 128'(n_out - o0), 128'(4));

    // Clear while main and skid are full and a new beat is offered.
    drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 1);
    step();
    drive(1, vecs[0].row, 3'd3, 1, 0, 8'h11, 0, 1, 0);
    step();
    drive(1, vecs[0].row, 3'd3, 1, 0, 8'h12, 0, 1, 0);
    step();
    #1;
    chk("pre-clear skid full ready", 128'(sreq_ready), 128'(0));
    chk("pre-clear ovf", 128'(ovf_sticky), 128'(1));
    drive(1, vecs[1].row, 3'd3, 1, 1, 8'h13, 1, 1, 1);
    step();
    #1;
    chk("post-clear wbuf_valid", 128'(wbuf_valid), 128'(0));
    chk("post-clear sreq_ready", 128'(sreq_ready), 128'(1));
    chk("post-clear ovf", 128'(ovf_sticky), 128'(0));
    drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 0);
    step();
    #1;
    chk("clear cycle accepted nothing", 128'(wbuf_valid), 128'(0));

    // Changing sinfo while a row is stalled must not disturb it.
    drive(1, vecs[0].row, 3'd3, 1, 0, 8'h21, 0, 1, 0);
    step();
    for (int l = 0; l < 8; l++) begin
      drive(0, rnd_row(), 3'(l), l[0], l[1], 8'h0, 0, 1, 0);
      step();
      #1;
      chk("stalled data vs lsa change", 128'(wbuf_data), vecs[0].d);
    end
    drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 0);
    step();

    // Random traffic.
    for (int c = 0; c < 500; c++) begin
      drive($urandom_range(0, 3) != 0, rnd_row(), 3'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, 8'($urandom),
            $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0);
      step();
    end

    // Asynchronous reset with rows pending.
    drive(1, vecs[0].row, 3'd3, 1, 0, 8'h31, 0, 1, 0);
    step();
    step();
    #2;
    rstnn = 1'b0;
    #1;
    chk("async reset wbuf_valid", 128'(wbuf_valid), 128'(0));
    chk("async reset ovf", 128'(ovf_sticky), 128'(0));
    q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rstnn = 1'b1;
    drive(0, '0, 3'd0, 0, 0, 8'h0, 1, 1, 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
